// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: owns the fetch PC, issues sequential word fetches over a
// credit-limited valid/ready request channel with in-order responses, queues
// returned words with their PCs in a DEPTH-entry FIFO for decode, and flushes
// everything (including words still in flight) on a redirect.
module instr_fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // instruction memory request channel
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  // instruction memory response channel (in order, no backpressure)
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  // redirect from execute
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  // decode channel
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  // Total credits shared between queued entries and fetches in flight.
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  // Architectural state
  logic [31:0] fetch_pc;     // address of the next request
  logic [31:0] resp_pc;      // PC belonging to the next kept response
  cnt_t        count;        // valid FIFO entries
  cnt_t        outstanding;  // accepted requests not yet answered
  cnt_t        drop_cnt;     // in-flight responses to discard after a redirect
  ptr_t        rd_ptr;
  ptr_t        wr_ptr;

  // FIFO storage
  logic [31:0] mem_data [DEPTH];
  logic [31:0] mem_pc   [DEPTH];

  // Derived control
  logic [CW:0] credits_used;
  logic [31:0] redirect_target;
  logic        req_fire;
  logic        drop_resp;
  logic        push;
  logic        pop;
  logic        head_valid;
  cnt_t        count_nxt;
  cnt_t        outstanding_nxt;

  // Redirect targets are forced to word alignment.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // A request may only issue while a FIFO slot is guaranteed for its response.
  assign credits_used   = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !rst && !redirect_valid && (credits_used < CREDITS);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is discarded if it is stale or arrives alongside a redirect.
  assign drop_resp = imem_resp_valid && (redirect_valid || (drop_cnt != '0));
  assign push      = imem_resp_valid && !drop_resp;

  // Decode sees the FIFO head; a redirect hides it in the flush cycle.
  assign head_valid  = (count != '0);
  assign instr_valid = head_valid && !redirect_valid;
  assign pop         = instr_valid && instr_ready;
  assign instr_data  = head_valid ? mem_data[rd_ptr] : '0;
  assign instr_pc    = head_valid ? mem_pc[rd_ptr]   : '0;

  // Next outstanding count: +1 per accepted request, -1 per response.
  // NOTE: always_comb uses blocking assignments and a default first, so each
  // term accumulates in order and no latch can be inferred.
  always_comb begin
    outstanding_nxt = outstanding;
    if (imem_resp_valid) outstanding_nxt = outstanding_nxt - cnt_t'(1);
    if (req_fire)        outstanding_nxt = outstanding_nxt + cnt_t'(1);
  end

  // Next FIFO occupancy: flush on redirect, otherwise push/pop balance.
  always_comb begin
    count_nxt = count;
    if (redirect_valid) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count + cnt_t'(1);
    end else if (pop && !push) begin
      count_nxt = count - cnt_t'(1);
    end
  end

  // Fetch PC and in-flight bookkeeping; a redirect restarts both PCs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        // No request issues in a redirect cycle, so everything still in
        // flight after this cycle's response is stale.
        drop_cnt <= outstanding_nxt;
      end else begin
        if (req_fire)  fetch_pc <= fetch_pc + 32'd4;
        if (push)      resp_pc  <= resp_pc + 32'd4;
        if (drop_resp) drop_cnt <= drop_cnt - cnt_t'(1);
      end
    end
  end

  // FIFO occupancy and pointers; a redirect empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count_nxt;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + ptr_t'(1);
        if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      end
    end
  end

  // FIFO storage write; entries are only visible when counted.
  // NOTE: the storage array is deliberately not reset; count gates every read,
  // so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= imem_resp_data;
      mem_pc[wr_ptr]   <= resp_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer: randomized bench with an in-order variable-latency
// memory and a queue-based reference model of the fetch buffer.
module tb_instr_fetch_buffer;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  instr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc)
  );

  always #5 clk = ~clk;

  // Reference model: fetches in flight (oldest first) and instructions queued
  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } flight_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  flight_t     inflight[$];
  entry_t      fifo[$];
  logic [31:0] m_fetch_pc;
  int          last_due;
  int          cyc;

  // Stimulus knobs
  int p_ready, p_iready, p_redir, lat_lo, lat_hi;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic set_knobs(input int rdy, input int irdy, input int redir, input int lo, input int hi);
    p_ready  = rdy;
    p_iready = irdy;
    p_redir  = redir;
    lat_lo   = lo;
    lat_hi   = hi;
  endtask

  task automatic model_reset();
    inflight.delete();
    fifo.delete();
    m_fetch_pc = RESET_PC;
    last_due   = cyc;
  endtask

  // One clock cycle: drive inputs on the falling edge, compare outputs against
  // the model, then advance the model by the events of this cycle.
  task automatic cycle(input bit fr = 1'b0, input logic [31:0] fpc = 32'h0);
    bit          exp_req, exp_iv, keep;
    logic [31:0] tgt;
    flight_t     f;
    entry_t      e;
    int          lat;
    @(negedge clk);
    imem_req_ready = ($urandom_range(99) < p_ready);
    instr_ready    = ($urandom_range(99) < p_iready);
    redirect_valid = fr || ($urandom_range(99) < p_redir);
    tgt            = fr ? fpc : $urandom;
    redirect_pc    = tgt;
    if (inflight.size() > 0 && inflight[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(inflight[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    #1;
    exp_req = !redirect_valid && (fifo.size() + inflight.size() < DEPTH);
    exp_iv  = (fifo.size() != 0) && !redirect_valid;
    check("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) check("req_addr", imem_req_addr, m_fetch_pc);
    check("instr_valid", 32'(instr_valid), 32'(exp_iv));
    if (exp_iv) begin
      check("instr_pc", instr_pc, fifo[0].pc);
      check("instr_data", instr_data, fifo[0].data);
    end
    if (imem_req_valid && imem_req_ready) n_acc++;

    keep = 1'b0;
    if (imem_resp_valid) begin
      f = inflight.pop_front();
      if (!redirect_valid && !f.stale) begin
        e.pc   = f.addr;
        e.data = mem_word(f.addr);
        keep   = 1'b1;
      end
    end
    if (redirect_valid) begin
      fifo.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      m_fetch_pc = tgt & 32'hFFFF_FFFC;
    end else begin
      if (exp_iv && instr_ready) void'(fifo.pop_front());
      if (keep) fifo.push_back(e);
      if (exp_req && imem_req_ready) begin
        lat     = int'($urandom_range(lat_hi, lat_lo));
        f.addr  = m_fetch_pc;
        f.stale = 1'b0;
        f.due   = cyc + lat;
        if (f.due <= last_due) f.due = last_due + 1;
        last_due = f.due;
        inflight.push_back(f);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
    check({tag, "_req_addr"}, imem_req_addr, RESET_PC);
    check({tag, "_instr_data"}, instr_data, 32'h0);
    check({tag, "_instr_pc"}, instr_pc, 32'h0);
  endtask

  // Asynchronous reset in the middle of a clock phase, synchronous release.
  task automatic mid_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    bit got;
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    instr_ready     = 1'b0;
    cyc             = 0;
    n_acc           = 0;
    set_knobs(100, 100, 0, 1, 1);

    repeat (3) @(negedge clk);
    #1 check_reset_outputs("por");
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;

    // Streaming: memory always ready, 1-cycle latency, decode always ready
    repeat (20) cycle();

    // Redirect coinciding with a response, a pop and a request
    cycle(1'b1, 32'h0000_0040);
    cycle();
    check("redir_next_addr", imem_req_addr, 32'h0000_0040);
    repeat (10) cycle();

    // Misaligned redirect target and PC wrap-around
    cycle(1'b1, 32'h0000_0203);
    cycle();
    check("align_addr", imem_req_addr, 32'h0000_0200);
    repeat (5) cycle();
    cycle(1'b1, 32'hFFFF_FFF8);
    cycle();
    check("wrap_addr0", imem_req_addr, 32'hFFFF_FFF8);
    cycle();
    check("wrap_addr1", imem_req_addr, 32'hFFFF_FFFC);
    cycle();
    check("wrap_addr2", imem_req_addr, 32'h0000_0000);
    repeat (10) cycle();

    // 3-cycle latency with fetches in flight, then redirect to 0x100
    set_knobs(100, 100, 0, 3, 3);
    repeat (12) cycle();
    cycle(1'b1, 32'h0000_0100);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (!got && instr_valid) begin
        got = 1'b1;
        check("redir_first_pc", instr_pc, 32'h0000_0100);
      end
    end
    check("redir_first_seen", 32'(got), 32'h1);

    // Randomized traffic with backpressure, variable latency and redirects
    set_knobs(70, 60, 6, 1, 4);
    repeat (400) cycle();

    // Reset with entries queued and fetches in flight
    set_knobs(100, 0, 0, 1, 3);
    repeat (6) cycle();
    mid_reset();

    // Decode stalled: exactly DEPTH requests accepted, then fetch stops
    set_knobs(100, 0, 0, 1, 1);
    n_acc = 0;
    cycle();
    check("post_rst_req_valid", 32'(imem_req_valid), 32'h1);
    check("post_rst_addr", imem_req_addr, RESET_PC);
    repeat (11) cycle();
    check("stall_accepts", 32'(n_acc), 32'(DEPTH));
    check("stall_req_valid", 32'(imem_req_valid), 32'h0);

    // Decode ready again: queued words drain in order and fetch resumes
    set_knobs(100, 100, 0, 1, 1);
    cycle();
    check("resume_addr", imem_req_addr, 32'h0000_0010);
    repeat (10) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
